// File: rtl/text_overlay_if.sv
// Raster, write-port and glyph-ROM signals of the text overlay controller.
// master = vga timing / host / ROM side, slave = text_overlay_ctrl.
interface text_overlay_if #(
    parameter int NCHARS = 8
);
    localparam int AW = $clog2(NCHARS);

    logic [9:0]    x;
    logic [9:0]    y;
    logic          valid;
    logic          newframe;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          wr_ready;
    logic          commit;
    logic          commit_pending;
    logic [3:0]    char_code;
    logic [2:0]    rownum;
    logic [7:0]    pixels;
    logic          pix_out;

    modport master (
        output x, y, valid, newframe, wr_en, wr_addr, wr_data, commit, pixels,
        input  wr_ready, commit_pending, char_code, rownum, pix_out
    );

    modport slave (
        input  x, y, valid, newframe, wr_en, wr_addr, wr_data, commit, pixels,
        output wr_ready, commit_pending, char_code, rownum, pix_out
    );
endinterface

// File: rtl/text_overlay_ctrl.sv
// One-line text overlay: double-buffered char string, glyph ROM sequencing, 2-clock pixel pipe.
// Optional 2x2 glyph scaling when TEXT_SCALE2_EN is defined.
module text_overlay_ctrl #(
    parameter int NCHARS     = 8,
    parameter int TEXT_X0    = 8,
    parameter int TEXT_Y0    = 300,
    parameter int BLANK_CODE = 15
) (
    input  logic             clk,
    input  logic             rst,
    text_overlay_if.slave    bus
);
    localparam int AW = $clog2(NCHARS);
`ifdef TEXT_SCALE2_EN
    localparam int LS = 1;
`else
    localparam int LS = 0;
`endif
    localparam int ROWS  = 8 << LS;
    localparam int WIN_W = NCHARS * (8 << LS);
    localparam logic [3:0] BLANK = 4'(BLANK_CODE);

    typedef enum logic [1:0] {WAIT_ROW, IN_ROWS, DONE} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             row_cnt_q, row_cnt_d;
    logic [NCHARS-1:0][3:0] shadow_q, active_q;
    logic                   pending_q;
    logic                   swap, wr_fire;
    logic [9:0]             c;
    logic                   in_win, line_start, last_col;
    logic [AW-1:0]          slot;
    logic [2:0]             bit_idx;
    logic [3:0]             char_q;
    logic [2:0]             rownum_q, bit_q;
    logic                   in_win_q, pix_q;

    // A swap steals the write port for its single cycle so the copy never races a write.
    assign swap     = bus.newframe && (pending_q || bus.commit);
    assign wr_fire  = bus.wr_en && !swap;
    assign bus.wr_ready       = rst || !swap;
    assign bus.commit_pending = pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= {NCHARS{BLANK}};
            active_q  <= {NCHARS{BLANK}};
            pending_q <= 1'b0;
        end else begin
            if (wr_fire) shadow_q[bus.wr_addr] <= bus.wr_data;
            if (swap) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end else if (bus.commit) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Underflow when x < TEXT_X0 wraps c high, so the range check rejects it as well.
    assign c          = bus.x - 10'(TEXT_X0);
    assign in_win     = (state_q == IN_ROWS) && bus.valid && (bus.x >= 10'(TEXT_X0))
                        && (c < 10'(WIN_W));
    assign slot       = AW'(c >> (3 + LS));
    assign bit_idx    = 3'(c >> LS);
    assign line_start = bus.valid && (bus.x == 10'd0);
    assign last_col   = bus.valid && (c == 10'(WIN_W - 1));

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        if (bus.newframe) begin
            state_d   = WAIT_ROW;
            row_cnt_d = 4'd0;
        end else begin
            case (state_q)
                WAIT_ROW: begin
                    if (line_start && bus.y == 10'(TEXT_Y0)) begin
                        state_d   = IN_ROWS;
                        row_cnt_d = 4'd0;
                    end
                end
                IN_ROWS: begin
                    if (line_start) row_cnt_d = row_cnt_q + 4'd1;
                    if (row_cnt_q == 4'(ROWS - 1) && last_col) state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_ROW;
            row_cnt_q <= 4'd0;
            char_q    <= BLANK;
            rownum_q  <= 3'd0;
            bit_q     <= 3'd0;
            in_win_q  <= 1'b0;
            pix_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            char_q    <= in_win ? active_q[slot] : BLANK;
            rownum_q  <= 3'(row_cnt_q >> LS);
            bit_q     <= bit_idx;
            in_win_q  <= in_win;
            pix_q     <= in_win_q & bus.pixels[3'd7 - bit_q];
        end
    end

    assign bus.char_code = char_q;
    assign bus.rownum    = rownum_q;
    assign bus.pix_out   = pix_q;
endmodule
